// File: rtl/axi_xbar_pkg.sv
// axi_xbar_pkg: shared FSM types, response codes and CLINT address decode for the AXI4-Lite crossbar
package axi_xbar_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_t;

    localparam logic [31:0] CLINT_BASE_DEF = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK_DEF = 32'hFFFF_0000;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic is_clint(input logic [31:0] addr, input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/axi_xbar_wr_path.sv
// axi_xbar_wr_path: write-channel FSM; accepts AW+W together, forwards them to one target, returns B
module axi_xbar_wr_path
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_awvalid_i,
    input  logic        s_wvalid_i,
    input  logic        s_bready_i,
    input  logic [31:0] s_awaddr_i,
    input  logic [31:0] s_wdata_i,
    input  logic [3:0]  s_wstrb_i,
    output logic        s_awready_o,
    output logic        s_wready_o,
    output logic        s_bvalid_o,
    output logic [1:0]  s_bresp_o,
    input  logic        c_awready_i,
    input  logic        c_wready_i,
    input  logic        c_bvalid_i,
    input  logic [1:0]  c_bresp_i,
    output logic        c_awvalid_o,
    output logic        c_wvalid_o,
    output logic        c_bready_o,
    output logic [31:0] c_awaddr_o,
    output logic [31:0] c_wdata_o,
    output logic [3:0]  c_wstrb_o,
    input  logic        m_awready_i,
    input  logic        m_wready_i,
    input  logic        m_bvalid_i,
    input  logic [1:0]  m_bresp_i,
    output logic        m_awvalid_o,
    output logic        m_wvalid_o,
    output logic        m_bready_o,
    output logic [31:0] m_awaddr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wstrb_o
);

    w_state_t    state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        sel_q, sel_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        accept, awv, wv, aw_hs, w_hs, b_phase, b_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= W_IDLE;
            sel_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

    always_comb begin
        accept      = state_q == W_IDLE && s_awvalid_i && s_wvalid_i;
        s_awready_o = accept;
        s_wready_o  = accept;
        awv         = state_q == W_REQ && !aw_done_q;
        wv          = state_q == W_REQ && !w_done_q;
        b_phase     = state_q == W_RESP;
        c_awvalid_o = awv && sel_q;
        m_awvalid_o = awv && !sel_q;
        c_wvalid_o  = wv && sel_q;
        m_wvalid_o  = wv && !sel_q;
        c_awaddr_o  = addr_q;
        m_awaddr_o  = addr_q;
        c_wdata_o   = data_q;
        m_wdata_o   = data_q;
        c_wstrb_o   = strb_q;
        m_wstrb_o   = strb_q;
        // Target B is only looked at in W_RESP: the CLINT keeps BVALID high all the time
        s_bvalid_o  = b_phase && (sel_q ? c_bvalid_i : m_bvalid_i);
        s_bresp_o   = b_phase ? (sel_q ? c_bresp_i : m_bresp_i) : OKAY;
        c_bready_o  = b_phase && sel_q && s_bready_i;
        m_bready_o  = b_phase && !sel_q && s_bready_i;
        aw_hs       = awv && (sel_q ? c_awready_i : m_awready_i);
        w_hs        = wv && (sel_q ? c_wready_i : m_wready_i);
        b_hs        = s_bvalid_o && s_bready_i;
        sel_d       = accept ? is_clint(s_awaddr_i, CLINT_BASE, CLINT_MASK) : sel_q;
        addr_d      = accept ? s_awaddr_i : addr_q;
        data_d      = accept ? s_wdata_i : data_q;
        strb_d      = accept ? s_wstrb_i : strb_q;
        aw_done_d   = accept ? 1'b0 : aw_done_q || aw_hs;
        w_done_d    = accept ? 1'b0 : w_done_q || w_hs;
        state_d     = accept ? W_REQ
                    : (state_q == W_REQ && aw_done_d && w_done_d) ? W_RESP
                    : b_hs ? W_IDLE
                    : state_q;
    end

endmodule

// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: one-master, two-target AXI4-Lite router (CLINT vs main bus) with independent read/write paths
module axi_lite_xbar
    import axi_xbar_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [31:0] CLINT_MASK = CLINT_MASK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_ARVALID,
    input  logic [31:0] s_ARADDR,
    output logic        s_ARREADY,
    output logic        s_RVALID,
    output logic [31:0] s_RDATA,
    output logic [1:0]  s_RRESP,
    input  logic        s_RREADY,
    input  logic        s_AWVALID,
    input  logic [31:0] s_AWADDR,
    output logic        s_AWREADY,
    input  logic        s_WVALID,
    input  logic [31:0] s_WDATA,
    input  logic [3:0]  s_WSTRB,
    output logic        s_WREADY,
    output logic        s_BVALID,
    output logic [1:0]  s_BRESP,
    input  logic        s_BREADY,
    output logic        c_ARVALID,
    output logic [31:0] c_ARADDR,
    input  logic        c_ARREADY,
    input  logic        c_RVALID,
    input  logic [31:0] c_RDATA,
    input  logic [1:0]  c_RRESP,
    output logic        c_RREADY,
    output logic        c_AWVALID,
    output logic [31:0] c_AWADDR,
    input  logic        c_AWREADY,
    output logic        c_WVALID,
    output logic [31:0] c_WDATA,
    output logic [3:0]  c_WSTRB,
    input  logic        c_WREADY,
    input  logic        c_BVALID,
    input  logic [1:0]  c_BRESP,
    output logic        c_BREADY,
    output logic        m_ARVALID,
    output logic [31:0] m_ARADDR,
    input  logic        m_ARREADY,
    input  logic        m_RVALID,
    input  logic [31:0] m_RDATA,
    input  logic [1:0]  m_RRESP,
    output logic        m_RREADY,
    output logic        m_AWVALID,
    output logic [31:0] m_AWADDR,
    input  logic        m_AWREADY,
    output logic        m_WVALID,
    output logic [31:0] m_WDATA,
    output logic [3:0]  m_WSTRB,
    input  logic        m_WREADY,
    input  logic        m_BVALID,
    input  logic [1:0]  m_BRESP,
    output logic        m_BREADY
);

    r_state_t    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic        rsel_q, rsel_d;
    logic        ar_hs, r_hs, r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rsel_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rsel_q    <= rsel_d;
        end
        raddr_q <= raddr_d;
    end

    always_comb begin
        s_ARREADY = r_state_q == R_IDLE;
        c_ARVALID = r_state_q == R_ADDR && rsel_q;
        m_ARVALID = r_state_q == R_ADDR && !rsel_q;
        c_ARADDR  = raddr_q;
        m_ARADDR  = raddr_q;
        r_data    = r_state_q == R_DATA;
        // Stale CLINT RVALID outside R_DATA must never reach the master
        s_RVALID  = r_data && (rsel_q ? c_RVALID : m_RVALID);
        s_RDATA   = rsel_q ? c_RDATA : m_RDATA;
        s_RRESP   = r_data ? (rsel_q ? c_RRESP : m_RRESP) : OKAY;
        c_RREADY  = r_data && rsel_q && s_RREADY;
        m_RREADY  = r_data && !rsel_q && s_RREADY;
        ar_hs     = s_ARVALID && s_ARREADY;
        r_hs      = s_RVALID && s_RREADY;
        rsel_d    = ar_hs ? is_clint(s_ARADDR, CLINT_BASE, CLINT_MASK) : rsel_q;
        raddr_d   = ar_hs ? s_ARADDR : raddr_q;
        r_state_d = ar_hs ? R_ADDR
                  : (r_state_q == R_ADDR && (rsel_q ? c_ARREADY : m_ARREADY)) ? R_DATA
                  : r_hs ? R_IDLE
                  : r_state_q;
    end

    axi_xbar_wr_path #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_MASK (CLINT_MASK)
    ) u_wr_path (
        .clk         (clk),
        .rst         (rst),
        .s_awvalid_i (s_AWVALID),
        .s_wvalid_i  (s_WVALID),
        .s_bready_i  (s_BREADY),
        .s_awaddr_i  (s_AWADDR),
        .s_wdata_i   (s_WDATA),
        .s_wstrb_i   (s_WSTRB),
        .s_awready_o (s_AWREADY),
        .s_wready_o  (s_WREADY),
        .s_bvalid_o  (s_BVALID),
        .s_bresp_o   (s_BRESP),
        .c_awready_i (c_AWREADY),
        .c_wready_i  (c_WREADY),
        .c_bvalid_i  (c_BVALID),
        .c_bresp_i   (c_BRESP),
        .c_awvalid_o (c_AWVALID),
        .c_wvalid_o  (c_WVALID),
        .c_bready_o  (c_BREADY),
        .c_awaddr_o  (c_AWADDR),
        .c_wdata_o   (c_WDATA),
        .c_wstrb_o   (c_WSTRB),
        .m_awready_i (m_AWREADY),
        .m_wready_i  (m_WREADY),
        .m_bvalid_i  (m_BVALID),
        .m_bresp_i   (m_BRESP),
        .m_awvalid_o (m_AWVALID),
        .m_wvalid_o  (m_WVALID),
        .m_bready_o  (m_BREADY),
        .m_awaddr_o  (m_AWADDR),
        .m_wdata_o   (m_WDATA),
        .m_wstrb_o   (m_WSTRB)
    );

endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb_axi_lite_xbar: random master plus two target models (CLINT with sticky BVALID/stale RVALID, main bus) vs transaction-level reference
module tb_axi_lite_xbar;
    import axi_xbar_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_ARVALID, s_ARREADY, s_RVALID, s_RREADY;
    logic        s_AWVALID, s_AWREADY, s_WVALID, s_WREADY, s_BVALID, s_BREADY;
    logic [31:0] s_ARADDR, s_RDATA, s_AWADDR, s_WDATA;
    logic [3:0]  s_WSTRB;
    logic [1:0]  s_RRESP, s_BRESP;
    logic        c_ARVALID, c_RREADY, c_AWVALID, c_WVALID, c_BREADY;
    logic        m_ARVALID, m_RREADY, m_AWVALID, m_WVALID, m_BREADY;
    logic [31:0] c_ARADDR, c_AWADDR, c_WDATA, m_ARADDR, m_AWADDR, m_WDATA;
    logic [3:0]  c_WSTRB, m_WSTRB;

    // Target-side drivers, index 1 = CLINT, 0 = main bus
    logic [1:0]  t_arready, t_rvalid, t_awready, t_wready, t_bvalid;
    logic [31:0] t_rdata [2];
    logic [1:0]  t_rresp [2];
    logic [1:0]  t_bresp [2];

    axi_lite_xbar dut (
        .clk(clk), .rst(rst),
        .s_ARVALID(s_ARVALID), .s_ARADDR(s_ARADDR), .s_ARREADY(s_ARREADY),
        .s_RVALID(s_RVALID), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RREADY(s_RREADY),
        .s_AWVALID(s_AWVALID), .s_AWADDR(s_AWADDR), .s_AWREADY(s_AWREADY),
        .s_WVALID(s_WVALID), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WREADY(s_WREADY),
        .s_BVALID(s_BVALID), .s_BRESP(s_BRESP), .s_BREADY(s_BREADY),
        .c_ARVALID(c_ARVALID), .c_ARADDR(c_ARADDR), .c_ARREADY(t_arready[1]),
        .c_RVALID(t_rvalid[1]), .c_RDATA(t_rdata[1]), .c_RRESP(t_rresp[1]), .c_RREADY(c_RREADY),
        .c_AWVALID(c_AWVALID), .c_AWADDR(c_AWADDR), .c_AWREADY(t_awready[1]),
        .c_WVALID(c_WVALID), .c_WDATA(c_WDATA), .c_WSTRB(c_WSTRB), .c_WREADY(t_wready[1]),
        .c_BVALID(t_bvalid[1]), .c_BRESP(t_bresp[1]), .c_BREADY(c_BREADY),
        .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARREADY(t_arready[0]),
        .m_RVALID(t_rvalid[0]), .m_RDATA(t_rdata[0]), .m_RRESP(t_rresp[0]), .m_RREADY(m_RREADY),
        .m_AWVALID(m_AWVALID), .m_AWADDR(m_AWADDR), .m_AWREADY(t_awready[0]),
        .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WREADY(t_wready[0]),
        .m_BVALID(t_bvalid[0]), .m_BRESP(t_bresp[0]), .m_BREADY(m_BREADY)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic in_clint(input logic [31:0] a);
        return a >= 32'h0200_0000 && a <= 32'h0200_FFFF;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        r = $urandom;
        case (r[3:0])
            4'd0: return 32'h0200_0000;
            4'd1: return 32'h0200_FFFF;
            4'd2: return 32'h0201_0000;
            4'd3: return 32'h01FF_FFFC;
            4'd4: return 32'h8000_0000;
            4'd5: return 32'h8000_0010;
            4'd6: return 32'h0200_0004;
            4'd7, 4'd8, 4'd9: return {16'h0200, r[31:18], 2'b00};
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    // Transaction-level reference state
    logic        rd_out, rd_got, ar_v, rd_sel;
    logic [31:0] rd_addr, r_data;
    logic [1:0]  r_resp;
    int          r_delay;
    logic        wr_out, aw_got, w_got, aw_v, w_v, wr_sel;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic [1:0]  b_resp;
    int          b_delay;
    logic        h_sar, h_tar, h_r, h_saw, h_taw, h_tw, h_b;
    logic        exp_arready, exp_rvalid, exp_acc, exp_bvalid;
    logic [1:0]  exp_arv, exp_rr, exp_awv, exp_wv, exp_br;
    logic        post_rst, did_mid, mid;
    int          rd_done, wr_done;

    task automatic clear_model();
        rd_out = 0; rd_got = 0; ar_v = 0; r_delay = 0;
        wr_out = 0; aw_got = 0; w_got = 0; aw_v = 0; w_v = 0; b_delay = 0;
        h_sar = 0; h_tar = 0; h_r = 0; h_saw = 0; h_taw = 0; h_tw = 0; h_b = 0;
    endtask

    initial begin
        clear_model();
        rd_sel = 0; wr_sel = 0; rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        r_data = 0; r_resp = OKAY; b_resp = OKAY;
        post_rst = 0; did_mid = 0; rd_done = 0; wr_done = 0;
        rst = 1;
        s_ARVALID = 0; s_ARADDR = 0; s_RREADY = 0;
        s_AWVALID = 0; s_AWADDR = 0; s_WVALID = 0; s_WDATA = 0; s_WSTRB = 0; s_BREADY = 0;
        t_arready = 0; t_rvalid = 0; t_awready = 0; t_wready = 0;
        t_bvalid = 2'b10;
        t_rdata[0] = 0; t_rdata[1] = 0; t_rresp[0] = OKAY; t_rresp[1] = OKAY;
        t_bresp[0] = OKAY; t_bresp[1] = SLVERR;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #6;
        check("reset_state", 32'({s_ARREADY, s_AWREADY, s_WREADY, s_RVALID, s_BVALID,
              c_ARVALID, m_ARVALID, c_AWVALID, m_AWVALID, c_WVALID, m_WVALID,
              c_RREADY, m_RREADY, c_BREADY, m_BREADY}), 32'h4000);

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 0;
                clear_model();
                post_rst = 1;
            end else begin
                if (rd_got && r_delay > 0) r_delay--;
                if (aw_got && w_got && b_delay > 0) b_delay--;
                if (h_sar) begin rd_out = 1; rd_got = 0; ar_v = 0; end
                if (h_tar) begin
                    rd_got = 1;
                    r_delay = $urandom_range(6, 0);
                    r_data = $urandom;
                    r_resp = 1'($urandom) ? SLVERR : OKAY;
                end
                if (h_r) begin rd_out = 0; rd_got = 0; rd_done++; end
                if (h_saw) begin wr_out = 1; aw_got = 0; w_got = 0; aw_v = 0; w_v = 0; end
                if (h_taw) aw_got = 1;
                if (h_tw) w_got = 1;
                if ((h_taw || h_tw) && aw_got && w_got) begin
                    b_delay = $urandom_range(5, 0);
                    b_resp = 1'($urandom) ? SLVERR : OKAY;
                end
                if (h_b) begin wr_out = 0; wr_done++; end
            end

            if (!rd_out && !ar_v && $urandom_range(2, 0) == 0) begin
                ar_v = 1;
                rd_addr = pick_addr();
                rd_sel = in_clint(rd_addr);
            end
            if (!wr_out && !aw_v && !w_v && $urandom_range(2, 0) == 0) begin
                wr_addr = pick_addr();
                wr_sel = in_clint(wr_addr);
                wr_data = $urandom;
                wr_strb = 4'($urandom);
                aw_v = 1'($urandom);
                w_v = aw_v ? 1'($urandom) : 1'b1;
            end else if (!wr_out && (aw_v || w_v)) begin
                if (!aw_v) aw_v = 1'($urandom);
                if (!w_v) w_v = 1'($urandom);
            end
            mid = !did_mid && cyc > 2000 && rd_got;
            if (mid) begin
                rst = 1;
                did_mid = 1;
                aw_v = 0;
                w_v = 0;
            end
            s_ARVALID = ar_v; s_ARADDR = rd_addr; s_RREADY = 1'($urandom);
            s_AWVALID = aw_v; s_AWADDR = wr_addr;
            s_WVALID = w_v; s_WDATA = wr_data; s_WSTRB = wr_strb; s_BREADY = 1'($urandom);

            for (int t = 0; t < 2; t++) begin
                t_arready[t] = 1'($urandom);
                t_awready[t] = 1'($urandom);
                t_wready[t] = 1'($urandom);
                if (rd_got && rd_sel == 1'(t)) begin
                    t_rvalid[t] = r_delay == 0;
                    t_rdata[t] = r_data;
                    t_rresp[t] = r_resp;
                end else begin
                    t_rvalid[t] = (t == 1) ? 1'($urandom) : 1'b0;
                    t_rdata[t] = $urandom;
                    t_rresp[t] = 2'($urandom);
                end
            end
            t_bvalid[1] = 1'b1;
            t_bresp[1] = SLVERR;
            t_bvalid[0] = wr_out && aw_got && w_got && !wr_sel && b_delay == 0;
            t_bresp[0] = b_resp;

            #6;
            exp_arready = !rd_out;
            for (int t = 0; t < 2; t++) begin
                exp_arv[t] = rd_out && !rd_got && rd_sel == 1'(t);
                exp_rr[t]  = rd_got && rd_sel == 1'(t) && s_RREADY;
                exp_awv[t] = wr_out && !aw_got && wr_sel == 1'(t);
                exp_wv[t]  = wr_out && !w_got && wr_sel == 1'(t);
                exp_br[t]  = wr_out && aw_got && w_got && wr_sel == 1'(t) && s_BREADY;
            end
            exp_rvalid = rd_got && t_rvalid[rd_sel];
            exp_bvalid = wr_out && aw_got && w_got && t_bvalid[wr_sel];
            exp_acc = !wr_out && aw_v && w_v;
            check("rd_ctl", 32'({s_ARREADY, c_ARVALID, m_ARVALID, s_RVALID, c_RREADY, m_RREADY}),
                  32'({exp_arready, exp_arv, exp_rvalid, exp_rr}));
            check("wr_ctl", 32'({s_AWREADY, s_WREADY, c_AWVALID, m_AWVALID, c_WVALID, m_WVALID,
                  s_BVALID, c_BREADY, m_BREADY}),
                  32'({exp_acc, exp_acc, exp_awv, exp_wv, exp_bvalid, exp_br}));
            h_sar = ar_v && exp_arready;
            h_tar = exp_arv[rd_sel] && t_arready[rd_sel];
            if (h_tar) check("ar_addr", rd_sel ? c_ARADDR : m_ARADDR, rd_addr);
            h_r = exp_rvalid && s_RREADY;
            if (h_r) begin
                check("rdata", s_RDATA, r_data);
                check("rresp", 32'(s_RRESP), 32'(r_resp));
            end
            h_saw = exp_acc;
            h_taw = exp_awv[wr_sel] && t_awready[wr_sel];
            if (h_taw) check("aw_addr", wr_sel ? c_AWADDR : m_AWADDR, wr_addr);
            h_tw = exp_wv[wr_sel] && t_wready[wr_sel];
            if (h_tw) begin
                check("wdata", wr_sel ? c_WDATA : m_WDATA, wr_data);
                check("wstrb", 32'(wr_sel ? c_WSTRB : m_WSTRB), 32'(wr_strb));
            end
            h_b = exp_bvalid && s_BREADY;
            if (h_b) check("bresp", 32'(s_BRESP), 32'(wr_sel ? SLVERR : b_resp));
            if (post_rst) begin
                check("mid_rst_state", 32'({s_ARREADY, c_ARVALID, m_ARVALID, c_AWVALID, m_AWVALID,
                      c_WVALID, m_WVALID, s_RVALID, s_BVALID}), 32'h100);
                post_rst = 0;
            end
        end

        check("rd_progress", 32'(rd_done >= 50), 32'd1);
        check("wr_progress", 32'(wr_done >= 50), 32'd1);
        check("mid_rst_hit", 32'(did_mid), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
